kplic: RTL

Platform-level interrupt controller that merges `SRC_NUM` external interrupt sources into the single `kplic_int` request consumed by the core's trap control unit, which synchronizes it into MEIP. Each source has a gateway, a priority and an enable. Software programs a threshold and runs the claim/complete protocol through a small memory-mapped register port.

---
 rtl/kplic_pkg.sv | 22 ++
 rtl/kplic_gateway.sv | 71 +++++++
 rtl/kplic.sv | 131 +++++++++++++
 3 files changed

// File: rtl/kplic_pkg.sv
// kplic_pkg: shared definitions for the platform-level interrupt controller.
//   - register byte offsets of the memory-mapped register port
//   - gateway FSM state encoding
//   - ID width (IDs 1..15, 0 = "no interrupt")
package kplic_pkg;

    localparam int ID_W = 4;

    localparam logic [7:0] KPLIC_PRIO_BASE = 8'h00;  // priority[i] at base + 4*i
    localparam logic [7:0] KPLIC_PENDING   = 8'h40;
    localparam logic [7:0] KPLIC_ENABLE    = 8'h44;
    localparam logic [7:0] KPLIC_THRESHOLD = 8'h48;
    localparam logic [7:0] KPLIC_CLAIM     = 8'h4C;
    localparam logic [7:0] KPLIC_TYPE      = 8'h50;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_SERV = 2'd2
    } gw_state_t;

endpackage

// File: rtl/kplic_gateway.sv
// kplic_gateway: per-source interrupt gateway.
// Synchronizes the raw request, detects rising edges and runs the
// IDLE -> PEND -> SERV -> IDLE handshake driven by claim/complete.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   src        : raw asynchronous source request
//   type_edge  : 1 = rising-edge triggered, 0 = level triggered
//   claim      : this source is being claimed this cycle
//   complete   : software completes this source this cycle
//   pending    : gateway is in PEND
import kplic_pkg::*;

module kplic_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic type_edge,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    gw_state_t state;
    logic      sync1, sync2, sync3;
    logic      edge_hold;
    logic      rise;

    // sync3 is only the edge-detect history; the level seen by the FSM is sync2.
    assign rise    = sync2 & ~sync3;
    assign pending = (state == GW_PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GW_IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            edge_hold <= 1'b0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
            sync3 <= sync2;
            case (state)
                GW_IDLE: begin
                    // An edge held over from the last service wins; any new
                    // edge arriving now is merged into it.
                    if (edge_hold) begin
                        state     <= GW_PEND;
                        edge_hold <= 1'b0;
                    end else if (type_edge ? rise : sync2) begin
                        state <= GW_PEND;
                    end
                end
                GW_PEND: begin
                    if (claim)
                        state <= GW_SERV;
                    if (type_edge && rise)
                        edge_hold <= 1'b1;
                end
                GW_SERV: begin
                    if (complete)
                        state <= GW_IDLE;
                    if (type_edge && rise)
                        edge_hold <= 1'b1;
                end
                default: state <= GW_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/kplic.sv
// kplic: platform-level interrupt controller.
// Merges SRC_NUM sources into one registered request kplic_int.
// Holds priority/enable/threshold/type registers, the arbiter and the
// register read mux; per-source handshake lives in kplic_gateway.
// Ports:
//   cpu_clk, cpu_rst          : clock, synchronous active-high reset
//   src_int[SRC_NUM]          : raw source requests, bit i-1 = ID i
//   reg_sel/reg_wr/reg_addr/reg_wdata : register access (write when reg_wr)
//   reg_rdata, reg_rdata_vld  : registered read data, one-cycle valid
//   kplic_int                 : registered interrupt request
import kplic_pkg::*;

module kplic #(
    parameter int SRC_NUM = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [SRC_NUM-1:0] src_int,
    input  logic               reg_sel,
    input  logic               reg_wr,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_rdata_vld,
    output logic               kplic_int
);

    logic [SRC_NUM:1][PRIO_W-1:0] prio;
    logic [SRC_NUM:1]             enable;
    logic [SRC_NUM:1]             src_type;
    logic [SRC_NUM:1]             pending;
    logic [SRC_NUM:1]             claim_vec;
    logic [SRC_NUM:1]             complete_vec;
    logic [PRIO_W-1:0]            threshold;
    logic [ID_W-1:0]              best_id;
    logic [PRIO_W-1:0]            best_prio;
    logic [31:0]                  rd_next;
    logic                         rd_req, wr_req;
    logic                         claim_fire, complete_fire;

    assign rd_req        = reg_sel & ~reg_wr;
    assign wr_req        = reg_sel &  reg_wr;
    assign claim_fire    = rd_req && (reg_addr == KPLIC_CLAIM);
    assign complete_fire = wr_req && (reg_addr == KPLIC_CLAIM);

    // Gateways. Claim only reaches the current winner, so a claim with
    // best_id == 0 touches nothing. Complete requires an exact ID match.
    for (genvar g = 1; g <= SRC_NUM; g++) begin : g_gw
        assign claim_vec[g]    = claim_fire && (best_id == ID_W'(g));
        assign complete_vec[g] = complete_fire && (reg_wdata == 32'(g));

        kplic_gateway u_gw (
            .clk       (cpu_clk),
            .rst       (cpu_rst),
            .src       (src_int[g-1]),
            .type_edge (src_type[g]),
            .claim     (claim_vec[g]),
            .complete  (complete_vec[g]),
            .pending   (pending[g])
        );
    end

    // Arbiter: scan from the highest ID down with >= so that on equal
    // priority the lowest ID is the last one to win.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = SRC_NUM; i >= 1; i--) begin
            if (pending[i] && enable[i] && (prio[i] > threshold) &&
                ((best_id == '0) || (prio[i] >= best_prio))) begin
                best_id   = ID_W'(i);
                best_prio = prio[i];
            end
        end
    end

    // Configuration registers.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            prio      <= '0;
            enable    <= '0;
            src_type  <= '0;
            threshold <= '0;
        end else if (wr_req) begin
            case (reg_addr)
                KPLIC_ENABLE:    enable    <= reg_wdata[SRC_NUM:1];
                KPLIC_THRESHOLD: threshold <= reg_wdata[PRIO_W-1:0];
                KPLIC_TYPE:      src_type  <= reg_wdata[SRC_NUM:1];
                default: begin
                    for (int i = 1; i <= SRC_NUM; i++)
                        if (reg_addr == KPLIC_PRIO_BASE + 8'(4 * i))
                            prio[i] <= reg_wdata[PRIO_W-1:0];
                end
            endcase
        end
    end

    // Read mux; unmapped addresses (including 0x00) read as zero.
    always_comb begin
        rd_next = '0;
        case (reg_addr)
            KPLIC_PENDING:   rd_next[SRC_NUM:1]  = pending;
            KPLIC_ENABLE:    rd_next[SRC_NUM:1]  = enable;
            KPLIC_THRESHOLD: rd_next[PRIO_W-1:0] = threshold;
            KPLIC_CLAIM:     rd_next[ID_W-1:0]   = best_id;
            KPLIC_TYPE:      rd_next[SRC_NUM:1]  = src_type;
            default: begin
                for (int i = 1; i <= SRC_NUM; i++)
                    if (reg_addr == KPLIC_PRIO_BASE + 8'(4 * i))
                        rd_next[PRIO_W-1:0] = prio[i];
            end
        endcase
    end

    // Registered outputs. A read issued in a reset cycle never produces
    // a valid response.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            reg_rdata     <= '0;
            reg_rdata_vld <= 1'b0;
            kplic_int     <= 1'b0;
        end else begin
            reg_rdata_vld <= rd_req;
            if (rd_req)
                reg_rdata <= rd_next;
            kplic_int <= (best_id != '0);
        end
    end

endmodule
